// File: rtl/rtl_handshake_serializer.sv
// Serialises a packed NUM-word packet into one WIDTH-bit beat per downstream handshake.
// Define RTL_HANDSHAKE_SERIALIZER_ASSERT_EN to include the protocol assertions.
module rtl_handshake_serializer #(
   parameter int WIDTH = 5,
   parameter int NUM   = 2,
   parameter int CNT_W = 8
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH*NUM-1:0] in_data,
   output logic                 handshake_valid,
   input  logic                 handshake_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [CNT_W-1:0]     beat_count,
   output logic                 busy
);

   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       idx_nxt;
   logic [WIDTH*NUM-1:0]   pkt;
   logic                   up_xfer;
   logic                   dn_xfer;

   // Valid/ready: a beat moves on any edge where valid and ready are both high;
   // valid is held with stable data until that edge, and ready may depend on valid.
   assign idx_nxt  = idx + IDX_W'(1);
   assign out_last = handshake_valid && (idx == LAST_IDX);
   assign busy     = (state == SEND);
   // Accepting on the final beat lets the next packet follow with no bubble.
   assign in_ready = RESETN && ((state == IDLE) || (out_last && handshake_ready));
   assign up_xfer  = in_valid && in_ready;
   assign dn_xfer  = handshake_valid && handshake_ready;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state           <= IDLE;
         idx             <= '0;
         pkt             <= '0;
         handshake_valid <= 1'b0;
         out_data        <= '0;
         beat_count      <= '0;
      end else begin
         if (dn_xfer) beat_count <= beat_count + CNT_W'(1);
         case (state)
            IDLE: begin
               if (up_xfer) begin
                  pkt             <= in_data;
                  idx             <= '0;
                  out_data        <= in_data[WIDTH-1:0];
                  handshake_valid <= 1'b1;
                  state           <= SEND;
               end
            end
            SEND: begin
               if (dn_xfer) begin
                  if (idx != LAST_IDX) begin
                     idx      <= idx_nxt;
                     out_data <= pkt[int'(idx_nxt)*WIDTH +: WIDTH];
                  end else if (up_xfer) begin
                     pkt      <= in_data;
                     idx      <= '0;
                     out_data <= in_data[WIDTH-1:0];
                  end else begin
                     handshake_valid <= 1'b0;
                     state           <= IDLE;
                  end
               end
            end
         endcase
      end
   end

`ifdef RTL_HANDSHAKE_SERIALIZER_ASSERT_EN
   ap_stall_stable: assert property (@(posedge CLK) disable iff (!RESETN)
      handshake_valid && !handshake_ready |=> handshake_valid && $stable(out_data) && $stable(out_last))
      else $error("ap_stall_stable");

   ap_last_valid: assert property (@(posedge CLK) disable iff (!RESETN)
      out_last |-> handshake_valid)
      else $error("ap_last_valid");

   ap_accept_valid: assert property (@(posedge CLK) disable iff (!RESETN)
      in_ready && in_valid |=> handshake_valid)
      else $error("ap_accept_valid");
`else
`endif

endmodule

// File: tb/tb_rtl_handshake_serializer.sv
// Directed bench for rtl_handshake_serializer: per-cycle vector table plus a
// streamed counter-wrap sequence checked against an expected-word queue.
module tb_rtl_handshake_serializer;

   localparam int WIDTH = 5;
   localparam int NUM   = 2;
   localparam int CNT_W = 8;

   logic                 CLK = 1'b0;
   logic                 RESETN;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH*NUM-1:0] in_data;
   logic                 handshake_valid;
   logic                 handshake_ready;
   logic [WIDTH-1:0]     out_data;
   logic                 out_last;
   logic [CNT_W-1:0]     beat_count;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;

   rtl_handshake_serializer #(.WIDTH(WIDTH), .NUM(NUM), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .handshake_valid(handshake_valid), .handshake_ready(handshake_ready),
      .out_data(out_data), .out_last(out_last),
      .beat_count(beat_count), .busy(busy)
   );

   // clock
   always #5 CLK = ~CLK;

   typedef struct {
      logic                 rn;
      logic                 iv;
      logic [WIDTH*NUM-1:0] id;
      logic                 hr;
      logic                 hv;
      logic [WIDTH-1:0]     od;
      logic                 ol;
      logic                 ir;
      logic                 bz;
      logic [CNT_W-1:0]     bc;
      logic                 chk_d;
   } vec_t;

   vec_t vecs[$];

   logic [WIDTH-1:0] exp_q[$];
   logic             exp_last_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_vec(input int k, input vec_t v);
      string tag;
      RESETN          = v.rn;
      in_valid        = v.iv;
      in_data         = v.id;
      handshake_ready = v.hr;
      #2;
      tag = $sformatf("v%0d", k);
      check({tag, ".valid"},    32'(handshake_valid), 32'(v.hv));
      check({tag, ".last"},     32'(out_last),        32'(v.ol));
      check({tag, ".in_ready"}, 32'(in_ready),        32'(v.ir));
      check({tag, ".busy"},     32'(busy),            32'(v.bz));
      check({tag, ".count"},    32'(beat_count),      32'(v.bc));
      if (v.chk_d) check({tag, ".data"}, 32'(out_data), 32'(v.od));
      @(posedge CLK);
      #1;
   endtask

   // rn iv id hr | hv od ol ir bz bc chk_d
   task automatic add(input logic rn, input logic iv, input logic [9:0] id, input logic hr,
                      input logic hv, input logic [4:0] od, input logic ol, input logic ir,
                      input logic bz, input logic [7:0] bc, input logic chk_d);
      vecs.push_back('{rn, iv, id, hr, hv, od, ol, ir, bz, bc, chk_d});
   endtask

   initial begin
      int cyc;
      int beats;
      int accepted;
      logic [9:0] pkt;

      RESETN = 1'b0; in_valid = 1'b0; in_data = '0; handshake_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;

      // reset state, then single packet {0A,15}
      add(1, 1, {5'h0A, 5'h15}, 1,  0, 5'h00, 0, 1, 0, 0, 1);
      add(1, 0, 10'h000,        1,  1, 5'h15, 0, 0, 1, 0, 1);
      add(1, 0, 10'h000,        1,  1, 5'h0A, 1, 1, 1, 1, 1);
      add(1, 0, 10'h000,        1,  0, 5'h00, 0, 1, 0, 2, 0);
      // backpressure on beat 0; upstream noise during SEND must be ignored
      add(1, 1, {5'h0A, 5'h15}, 0,  0, 5'h00, 0, 1, 0, 2, 0);
      add(1, 0, 10'h000,        0,  1, 5'h15, 0, 0, 1, 2, 1);
      add(1, 1, 10'h3FF,        0,  1, 5'h15, 0, 0, 1, 2, 1);
      add(1, 1, 10'h3FF,        0,  1, 5'h15, 0, 0, 1, 2, 1);
      add(1, 0, 10'h000,        1,  1, 5'h15, 0, 0, 1, 2, 1);
      add(1, 0, 10'h000,        1,  1, 5'h0A, 1, 1, 1, 3, 1);
      add(1, 0, 10'h000,        0,  0, 5'h00, 0, 1, 0, 4, 0);
      // back-to-back P0={1,2}, P1={3,4}
      add(1, 1, {5'd1, 5'd2},   1,  0, 5'h00, 0, 1, 0, 4, 0);
      add(1, 1, {5'd3, 5'd4},   1,  1, 5'd2,  0, 0, 1, 4, 1);
      add(1, 1, {5'd3, 5'd4},   1,  1, 5'd1,  1, 1, 1, 5, 1);
      add(1, 0, 10'h000,        1,  1, 5'd4,  0, 0, 1, 6, 1);
      add(1, 0, 10'h000,        1,  1, 5'd3,  1, 1, 1, 7, 1);
      add(1, 0, 10'h000,        0,  0, 5'h00, 0, 1, 0, 8, 0);
      // reset after beat 0 of {7,9}, then {5,6}
      add(1, 1, {5'd7, 5'd9},   1,  0, 5'h00, 0, 1, 0, 8, 0);
      add(1, 0, 10'h000,        1,  1, 5'd9,  0, 0, 1, 8, 1);
      add(0, 0, 10'h000,        0,  1, 5'd7,  1, 0, 1, 9, 1);
      add(1, 0, 10'h000,        0,  0, 5'h00, 0, 1, 0, 0, 1);
      add(1, 1, {5'd5, 5'd6},   1,  0, 5'h00, 0, 1, 0, 0, 1);
      add(1, 0, 10'h000,        1,  1, 5'd6,  0, 0, 1, 0, 1);
      add(1, 0, 10'h000,        1,  1, 5'd5,  1, 1, 1, 1, 1);
      add(1, 0, 10'h000,        0,  0, 5'h00, 0, 1, 0, 2, 0);

      foreach (vecs[k]) apply_vec(k, vecs[k]);

      // counter wrap: 130 back-to-back packets, 260 beats
      RESETN = 1'b0; in_valid = 1'b0; handshake_ready = 1'b0;
      @(posedge CLK); #1;
      RESETN = 1'b1;
      cyc = 0; beats = 0; accepted = 0;
      while (beats < 260 && cyc < 400) begin
         pkt = 10'($urandom_range(0, 1023));
         in_valid        = (accepted < 130);
         in_data         = pkt;
         handshake_ready = 1'b1;
         #2;
         if (handshake_valid && handshake_ready) begin
            if (exp_q.size() == 0) begin
               check("wrap.unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               check("wrap.data", 32'(out_data), 32'(exp_q.pop_front()));
               check("wrap.last", 32'(out_last), 32'(exp_last_q.pop_front()));
            end
            beats++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(pkt[4:0]);  exp_last_q.push_back(1'b0);
            exp_q.push_back(pkt[9:5]);  exp_last_q.push_back(1'b1);
            accepted++;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("wrap.beats_done", 32'(beats), 32'd260);
      check("wrap.no_bubble_cycles", 32'(cyc), 32'd261);
      #2;
      check("wrap.beat_count", 32'(beat_count), 32'd4);
      check("wrap.idle_valid", 32'(handshake_valid), 32'd0);
      check("wrap.idle_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
